// File: rtl/trace_inject_sched.sv
// Trace-driven injection scheduler for the 4x4 mesh: walks the trace memory in order,
// releases each entry at its cycle and holds it until the source port accepts it.
// Define SCHED_STATS_EN to build the stall/late statistics counters.
module trace_inject_sched #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned BASE_ADDR = 1,
    parameter int unsigned NODE_W    = 4,
    parameter int unsigned NUM_NODES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 pause,
    input  logic [ADDR_W-1:0]    num_entries,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [39:0]          mem_rdata,
    input  logic [NUM_NODES-1:0] node_ready,
    output logic                 inj_valid,
    output logic [NODE_W-1:0]    inj_src,
    output logic [NODE_W-1:0]    inj_dest,
    output logic [31:0]          ctr,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          late_cnt
);

    localparam int unsigned CYC_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ARMED,
        S_INJECT,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [NODE_W-1:0] src;
        logic [NODE_W-1:0] dest;
        logic [CYC_W-1:0]  cyc;
    } entry_t;

    state_e            state_q, state_d;
    entry_t            entry_q;
    logic              rd_pend_q;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [CYC_W-1:0]  ctr_q, ctr_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic              inj_valid_q, inj_valid_d;
    logic [NODE_W-1:0] inj_src_q, inj_src_d;
    logic [NODE_W-1:0] inj_dest_q, inj_dest_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              idle_c;
    logic              start_go_c;
    logic              drop_c;
    logic              release_c;
    logic              handshake_c;
    logic              advance_c;
    logic [CYC_W-1:0]  ctr_nxt_c;

    // Release is judged on the counter value of the cycle in which inj_valid becomes visible.
    assign idle_c      = (state_q == S_IDLE) || (state_q == S_DONE);
    assign ctr_nxt_c   = ctr_q + CYC_W'(1);
    assign start_go_c  = idle_c && start && !stop && !pause && (num_entries != '0);
    assign drop_c      = (state_q == S_ARMED) && (entry_q.src == entry_q.dest);
    assign release_c   = (state_q == S_ARMED) && !drop_c && (ctr_nxt_c >= entry_q.cyc);
    assign handshake_c = (state_q == S_INJECT) && inj_valid_q && node_ready[inj_src_q];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        ctr_d       = ctr_q;
        mem_rd_en_d = mem_rd_en_q;
        mem_addr_d  = mem_addr_q;
        inj_valid_d = inj_valid_q;
        inj_src_d   = inj_src_q;
        inj_dest_d  = inj_dest_q;
        busy_d      = busy_q;
        done_d      = done_q;
        advance_c   = 1'b0;

        if (stop) begin
            state_d = S_IDLE;
        end else if (!pause) begin
            if (!idle_c) begin
                ctr_d = ctr_nxt_c;
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_go_c) begin
                        ctr_d   = '0;
                        ptr_d   = ADDR_W'(BASE_ADDR);
                        rem_d   = num_entries;
                        state_d = S_FETCH;
                    end else if (start) begin
                        state_d = S_DONE;
                    end
                end
                S_FETCH: state_d = S_WAIT;
                S_WAIT:  state_d = S_ARMED;
                S_ARMED: begin
                    if (drop_c) begin
                        advance_c = 1'b1;
                    end else if (release_c) begin
                        state_d    = S_INJECT;
                        inj_src_d  = entry_q.src;
                        inj_dest_d = entry_q.dest;
                    end
                end
                S_INJECT: advance_c = handshake_c;
                default:  state_d = S_IDLE;
            endcase
            // Dropped entries retire exactly like an accepted injection.
            if (advance_c) begin
                ptr_d   = ptr_q + ADDR_W'(1);
                rem_d   = rem_q - ADDR_W'(1);
                state_d = (rem_q == ADDR_W'(1)) ? S_DONE : S_FETCH;
            end
        end

        if (stop || !pause) begin
            mem_rd_en_d = (state_d == S_FETCH);
            inj_valid_d = (state_d == S_INJECT);
            busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
            done_d      = (state_d == S_DONE);
            if (state_d == S_FETCH) begin
                mem_addr_d = ptr_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= ADDR_W'(BASE_ADDR);
            rem_q       <= '0;
            ctr_q       <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            inj_valid_q <= 1'b0;
            inj_src_q   <= '0;
            inj_dest_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            ctr_q       <= ctr_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            inj_valid_q <= inj_valid_d;
            inj_src_q   <= inj_src_d;
            inj_dest_q  <= inj_dest_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Read data arrives the cycle after each strobed read; capture it then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q <= 1'b0;
            entry_q   <= '0;
        end else begin
            rd_pend_q <= mem_rd_en_q;
            if (rd_pend_q) begin
                entry_q <= entry_t'(mem_rdata);
            end
        end
    end

`ifdef SCHED_STATS_EN
    logic [CYC_W-1:0] stall_q, stall_d;
    logic [CYC_W-1:0] late_q, late_d;
    logic             stall_hit_c;
    logic             late_hit_c;

    assign stall_hit_c = inj_valid_q && !node_ready[inj_src_q] && !pause && !stop;
    assign late_hit_c  = release_c && (ctr_nxt_c > entry_q.cyc) && !pause && !stop;

    always_comb begin
        stall_d = stall_q;
        late_d  = late_q;
        if (start_go_c) begin
            stall_d = '0;
            late_d  = '0;
        end else begin
            if (stall_hit_c && (stall_q != '1)) begin
                stall_d = stall_q + CYC_W'(1);
            end
            if (late_hit_c && (late_q != '1)) begin
                late_d = late_q + CYC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            late_q  <= '0;
        end else begin
            stall_q <= stall_d;
            late_q  <= late_d;
        end
    end

    assign stall_cnt = stall_q;
    assign late_cnt  = late_q;
`else
    assign stall_cnt = '0;
    assign late_cnt  = '0;
`endif

    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign inj_valid = inj_valid_q;
    assign inj_src   = inj_src_q;
    assign inj_dest  = inj_dest_q;
    assign ctr       = ctr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
